// File: rtl/score_match_controller_if.sv
// Port bundle between the two pushbutton processors, the match controller and the display path.
// Inputs are single-cycle strobes with no backpressure: a 1 sampled on a rising clock edge is one event.
interface score_match_controller_if;
    logic       p1_short_i;
    logic       p2_short_i;
    logic       p1_long_i;
    logic       p2_long_i;
    logic [6:0] score_p1_o;
    logic [6:0] score_p2_o;
    logic [6:0] score_o;
    logic       disp_sel_o;
    logic       disp_blank_o;
    logic       game_over_o;
    logic [1:0] winner_o;
    logic [1:0] state_o;

    modport master (
        output p1_short_i, p2_short_i, p1_long_i, p2_long_i,
        input  score_p1_o, score_p2_o, score_o, disp_sel_o, disp_blank_o,
        input  game_over_o, winner_o, state_o
    );

    modport slave (
        input  p1_short_i, p2_short_i, p1_long_i, p2_long_i,
        output score_p1_o, score_p2_o, score_o, disp_sel_o, disp_blank_o,
        output game_over_o, winner_o, state_o
    );
endinterface

// File: rtl/score_match_controller.sv
// Two-player match sequencer: scoring, round-robin arbitration, win detection and display muxing.
// Optional SCOREBOARD_WIN_BY_TWO_EN: a win also needs a 2-point lead (reaching 99 always wins).
module score_match_controller #(
    parameter int WIN_SCORE      = 21,
    parameter int DISP_PERIOD_MS = 500,
    parameter int BLINK_MS       = 250
) (
    input logic clk_1khz_i,
    input logic rst_n_i,
    score_match_controller_if.slave bus
);
    localparam int CNT_MAX = (DISP_PERIOD_MS > BLINK_MS) ? DISP_PERIOD_MS : BLINK_MS;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] DISP_LAST  = CNT_W'(DISP_PERIOD_MS - 1);
    localparam logic [CNT_W-1:0] BLINK_LAST = CNT_W'(BLINK_MS - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [6:0] WIN_VAL   = 7'(WIN_SCORE);
    localparam logic [6:0] MAX_SCORE = 7'd99;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        WON  = 2'd2
    } state_t;

    state_t           state, state_n;
    logic [6:0]       score_p1, score_p2, p1_n, p2_n;
    logic [6:0]       inc_p1, inc_p2;
    logic [6:0]       score_mux, score_n;
    logic             pend_p1, pend_p2, pend1_n, pend2_n;
    logic             rr_p2, rr_n;
    logic             disp_sel, sel_n;
    logic             disp_blank, blank_n;
    logic             game_over, game_over_n;
    logic [1:0]       winner, winner_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic             req1, req2, grant1, grant2;
    logic             win_p1, win_p2;
    logic             any_long;

    assign inc_p1   = (score_p1 >= MAX_SCORE) ? MAX_SCORE : score_p1 + 7'd1;
    assign inc_p2   = (score_p2 >= MAX_SCORE) ? MAX_SCORE : score_p2 + 7'd1;
    assign any_long = bus.p1_long_i | bus.p2_long_i;

    // Only the scoring player's value changes in a cycle, so the other side's current score is the rival.
`ifdef SCOREBOARD_WIN_BY_TWO_EN
    assign win_p1 = (inc_p1 >= MAX_SCORE) ||
                    ((inc_p1 >= WIN_VAL) && (inc_p1 >= score_p2 + 7'd2));
    assign win_p2 = (inc_p2 >= MAX_SCORE) ||
                    ((inc_p2 >= WIN_VAL) && (inc_p2 >= score_p1 + 7'd2));
`else
    assign win_p1 = inc_p1 >= WIN_VAL;
    assign win_p2 = inc_p2 >= WIN_VAL;
`endif

    always_comb begin
        state_n  = state;
        p1_n     = score_p1;
        p2_n     = score_p2;
        pend1_n  = pend_p1;
        pend2_n  = pend_p2;
        rr_n     = rr_p2;
        sel_n    = disp_sel;
        blank_n  = disp_blank;
        winner_n = winner;
        cnt_n    = cnt;
        req1     = bus.p1_short_i | pend_p1;
        req2     = bus.p2_short_i | pend_p2;
        grant1   = 1'b0;
        grant2   = 1'b0;

        if (any_long) begin
            state_n  = IDLE;
            p1_n     = 7'd0;
            p2_n     = 7'd0;
            pend1_n  = 1'b0;
            pend2_n  = 1'b0;
            sel_n    = 1'b0;
            blank_n  = 1'b0;
            winner_n = 2'b00;
            cnt_n    = '0;
        end else if (state == WON) begin
            if (cnt == BLINK_LAST) begin
                blank_n = ~disp_blank;
                cnt_n   = '0;
            end else begin
                cnt_n = cnt + CNT_ONE;
            end
        end else begin
            // A pending point re-enters arbitration as a request; the flipped pointer makes it win next cycle.
            if (req1 && req2) begin
                grant1  = ~rr_p2;
                grant2  = rr_p2;
                pend1_n = rr_p2;
                pend2_n = ~rr_p2;
                rr_n    = ~rr_p2;
            end else begin
                grant1  = req1;
                grant2  = req2;
                pend1_n = 1'b0;
                pend2_n = 1'b0;
            end

            if (grant1) begin
                p1_n    = inc_p1;
                sel_n   = 1'b0;
                cnt_n   = '0;
                state_n = PLAY;
                if (win_p1) begin
                    state_n  = WON;
                    winner_n = 2'b01;
                    pend1_n  = 1'b0;
                    pend2_n  = 1'b0;
                end
            end else if (grant2) begin
                p2_n    = inc_p2;
                sel_n   = 1'b1;
                cnt_n   = '0;
                state_n = PLAY;
                if (win_p2) begin
                    state_n  = WON;
                    winner_n = 2'b10;
                    pend1_n  = 1'b0;
                    pend2_n  = 1'b0;
                end
            end else if (cnt == DISP_LAST) begin
                sel_n = ~disp_sel;
                cnt_n = '0;
            end else begin
                cnt_n = cnt + CNT_ONE;
            end
        end
    end

    assign game_over_n = (state_n == WON);
    assign score_n     = sel_n ? p2_n : p1_n;

    always_ff @(posedge clk_1khz_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state      <= IDLE;
            score_p1   <= 7'd0;
            score_p2   <= 7'd0;
            pend_p1    <= 1'b0;
            pend_p2    <= 1'b0;
            rr_p2      <= 1'b0;
            disp_sel   <= 1'b0;
            disp_blank <= 1'b0;
            game_over  <= 1'b0;
            winner     <= 2'b00;
            cnt        <= '0;
            score_mux  <= 7'd0;
        end else begin
            state      <= state_n;
            score_p1   <= p1_n;
            score_p2   <= p2_n;
            pend_p1    <= pend1_n;
            pend_p2    <= pend2_n;
            rr_p2      <= rr_n;
            disp_sel   <= sel_n;
            disp_blank <= blank_n;
            game_over  <= game_over_n;
            winner     <= winner_n;
            cnt        <= cnt_n;
            score_mux  <= score_n;
        end
    end

    assign bus.score_p1_o   = score_p1;
    assign bus.score_p2_o   = score_p2;
    assign bus.score_o      = score_mux;
    assign bus.disp_sel_o   = disp_sel;
    assign bus.disp_blank_o = disp_blank;
    assign bus.game_over_o  = game_over;
    assign bus.winner_o     = winner;
    assign bus.state_o      = state;
endmodule

// File: tb/tb_score_match_controller.sv
// Self-checking bench for score_match_controller: vector table, hand-written corner sequences,
// and randomized pulses checked against a rule-level match model.
module tb_score_match_controller;
    localparam int WIN   = 21;
    localparam int DISP  = 500;
    localparam int BLINK = 250;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    score_match_controller_if bus_if();

    score_match_controller #(
        .WIN_SCORE     (WIN),
        .DISP_PERIOD_MS(DISP),
        .BLINK_MS      (BLINK)
    ) dut (
        .clk_1khz_i(clk),
        .rst_n_i   (rst_n),
        .bus       (bus_if)
    );

    int checks   = 0;
    int failures = 0;

    // Match model: scores per player, state 0 idle / 1 play / 2 won, pending player, favoured player,
    // and the edge at which the display schedule was last restarted.
    int m_score[1:2];
    int m_state;
    int m_pend;
    int m_fav;
    int m_winner;
    int m_anchor;
    int m_anchor_sel;
    int m_cyc = 0;

    typedef struct {
        bit s1, s2, l1, l2;
        int e1, e2, esel;
    } vec_t;
    vec_t vecs[11];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_score[1]   = 0;
        m_score[2]   = 0;
        m_state      = 0;
        m_pend       = 0;
        m_fav        = 1;
        m_winner     = 0;
        m_anchor     = m_cyc;
        m_anchor_sel = 0;
    endtask

    function automatic bit model_wins(input int who);
        int me;
`ifdef SCOREBOARD_WIN_BY_TWO_EN
        int them;
        me   = m_score[who];
        them = m_score[3 - who];
        return (me == 99) || (me >= WIN && me - them >= 2);
`else
        me = m_score[who];
        return me >= WIN;
`endif
    endfunction

    task automatic model_step(input bit s1, input bit s2, input bit l1, input bit l2);
        bit want1, want2;
        int who;
        m_cyc++;
        if (l1 || l2) begin
            m_score[1]   = 0;
            m_score[2]   = 0;
            m_state      = 0;
            m_pend       = 0;
            m_winner     = 0;
            m_anchor     = m_cyc;
            m_anchor_sel = 0;
            return;
        end
        if (m_state == 2) return;
        want1 = s1 || (m_pend == 1);
        want2 = s2 || (m_pend == 2);
        who = 0;
        if (want1 && want2) begin
            who    = m_fav;
            m_pend = 3 - m_fav;
            m_fav  = 3 - m_fav;
        end else begin
            m_pend = 0;
            if (want1) who = 1;
            else if (want2) who = 2;
        end
        if (who != 0) begin
            if (m_score[who] < 99) m_score[who]++;
            m_state      = 1;
            m_anchor     = m_cyc;
            m_anchor_sel = who - 1;
            if (model_wins(who)) begin
                m_state  = 2;
                m_winner = who;
                m_pend   = 0;
            end
        end
    endtask

    function automatic int m_sel();
        if (m_state == 2) return m_winner - 1;
        return m_anchor_sel ^ (((m_cyc - m_anchor) / DISP) % 2);
    endfunction

    function automatic int m_blank();
        if (m_state != 2) return 0;
        return ((m_cyc - m_anchor) / BLINK) % 2;
    endfunction

    task automatic check_model(input string tag);
        int sel;
        sel = m_sel();
        check({tag, "_p1"},     int'(bus_if.score_p1_o),   m_score[1]);
        check({tag, "_p2"},     int'(bus_if.score_p2_o),   m_score[2]);
        check({tag, "_sel"},    int'(bus_if.disp_sel_o),   sel);
        check({tag, "_score"},  int'(bus_if.score_o),      sel ? m_score[2] : m_score[1]);
        check({tag, "_blank"},  int'(bus_if.disp_blank_o), m_blank());
        check({tag, "_over"},   int'(bus_if.game_over_o),  (m_state == 2) ? 1 : 0);
        check({tag, "_winner"}, int'(bus_if.winner_o),     m_winner);
        check({tag, "_state"},  int'(bus_if.state_o),      m_state);
    endtask

    task automatic tick(input bit s1, input bit s2, input bit l1, input bit l2);
        @(negedge clk);
        bus_if.p1_short_i = s1;
        bus_if.p2_short_i = s2;
        bus_if.p1_long_i  = l1;
        bus_if.p2_long_i  = l2;
        @(posedge clk);
        #1;
        model_step(s1, s2, l1, l2);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_p1"},     int'(bus_if.score_p1_o),   0);
        check({tag, "_p2"},     int'(bus_if.score_p2_o),   0);
        check({tag, "_score"},  int'(bus_if.score_o),      0);
        check({tag, "_sel"},    int'(bus_if.disp_sel_o),   0);
        check({tag, "_blank"},  int'(bus_if.disp_blank_o), 0);
        check({tag, "_over"},   int'(bus_if.game_over_o),  0);
        check({tag, "_winner"}, int'(bus_if.winner_o),     0);
        check({tag, "_state"},  int'(bus_if.state_o),      0);
    endtask

    // Asserts reset between clock edges so the async path is observed before any edge.
    task automatic async_reset(input string tag);
        @(negedge clk);
        bus_if.p1_short_i = 1'b0;
        bus_if.p2_short_i = 1'b0;
        bus_if.p1_long_i  = 1'b0;
        bus_if.p2_long_i  = 1'b0;
        #2 rst_n = 1'b0;
        #1 check_reset_values(tag);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    initial begin
        #5_000_000;
        failures++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        bus_if.p1_short_i = 1'b0;
        bus_if.p2_short_i = 1'b0;
        bus_if.p1_long_i  = 1'b0;
        bus_if.p2_long_i  = 1'b0;

        vecs[0]  = '{1, 0, 0, 0, 1, 0, 0};
        vecs[1]  = '{1, 0, 0, 0, 2, 0, 0};
        vecs[2]  = '{1, 0, 0, 0, 3, 0, 0};
        vecs[3]  = '{0, 1, 0, 0, 3, 1, 1};
        vecs[4]  = '{1, 1, 0, 0, 4, 1, 0};
        vecs[5]  = '{0, 0, 0, 0, 4, 2, 1};
        vecs[6]  = '{1, 1, 0, 0, 4, 3, 1};
        vecs[7]  = '{0, 0, 0, 0, 5, 3, 0};
        vecs[8]  = '{1, 1, 0, 1, 0, 0, 0};
        vecs[9]  = '{1, 0, 0, 0, 1, 0, 0};
        vecs[10] = '{1, 0, 0, 1, 0, 0, 0};

        repeat (3) @(posedge clk);
        #1 check_reset_values("por");
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();

        for (int i = 0; i < 11; i++) begin
            tick(vecs[i].s1, vecs[i].s2, vecs[i].l1, vecs[i].l2);
            check($sformatf("vec%0d_p1", i),  int'(bus_if.score_p1_o), vecs[i].e1);
            check($sformatf("vec%0d_p2", i),  int'(bus_if.score_p2_o), vecs[i].e2);
            check($sformatf("vec%0d_sel", i), int'(bus_if.disp_sel_o), vecs[i].esel);
            check($sformatf("vec%0d_score", i), int'(bus_if.score_o),
                  vecs[i].esel ? vecs[i].e2 : vecs[i].e1);
            check_model($sformatf("vec%0d_m", i));
        end

        // Reset mid-match at 5:3
        repeat (5) tick(1, 0, 0, 0);
        repeat (3) tick(0, 1, 0, 0);
        check("mid_p1", int'(bus_if.score_p1_o), 5);
        check("mid_p2", int'(bus_if.score_p2_o), 3);
        async_reset("midrst");
        #1 check("post_rst_score", int'(bus_if.score_o), 0);
        check("post_rst_state", int'(bus_if.state_o), 0);
        tick(0, 1, 0, 0);
        check("post_rst_no_pend_p1", int'(bus_if.score_p1_o), 0);
        check_model("post_rst");
        async_reset("rst2");

        // Display alternation after 500 quiet cycles
        repeat (3) tick(1, 0, 0, 0);
        check("disp_p1", int'(bus_if.score_p1_o), 3);
        check("disp_sel0", int'(bus_if.disp_sel_o), 0);
        check("disp_state", int'(bus_if.state_o), 1);
        repeat (499) begin
            tick(0, 0, 0, 0);
            check_model("disp_wait");
        end
        check("disp_sel_before", int'(bus_if.disp_sel_o), 0);
        tick(0, 0, 0, 0);
        check("disp_sel_after", int'(bus_if.disp_sel_o), 1);
        check("disp_score_p2", int'(bus_if.score_o), 0);
        check("disp_score_p1_held", int'(bus_if.score_p1_o), 3);

        // Long beats short at 7:4
        tick(0, 0, 1, 0);
        repeat (7) tick(1, 0, 0, 0);
        repeat (4) tick(0, 1, 0, 0);
        check("pre_long_p1", int'(bus_if.score_p1_o), 7);
        check("pre_long_p2", int'(bus_if.score_p2_o), 4);
        tick(1, 0, 0, 1);
        check("long_p1", int'(bus_if.score_p1_o), 0);
        check("long_p2", int'(bus_if.score_p2_o), 0);
        check("long_state", int'(bus_if.state_o), 0);
        check("long_score", int'(bus_if.score_o), 0);
        check_model("long");

        // Player 1 wins from 20:0, then blink
        repeat (20) tick(1, 0, 0, 0);
        check("pre_win_p1", int'(bus_if.score_p1_o), 20);
        check("pre_win_over", int'(bus_if.game_over_o), 0);
        tick(1, 0, 0, 0);
        check("win_p1", int'(bus_if.score_p1_o), 21);
        check("win_winner", int'(bus_if.winner_o), 1);
        check("win_over", int'(bus_if.game_over_o), 1);
        check("win_state", int'(bus_if.state_o), 2);
        check("win_sel", int'(bus_if.disp_sel_o), 0);
        check("win_score", int'(bus_if.score_o), 21);
        check("win_blank", int'(bus_if.disp_blank_o), 0);
        tick(1, 1, 0, 0);
        check("won_ignore_p1", int'(bus_if.score_p1_o), 21);
        check("won_ignore_p2", int'(bus_if.score_p2_o), 0);
        repeat (248) begin
            tick(0, 0, 0, 0);
            check_model("blink_a");
        end
        check("blink_0", int'(bus_if.disp_blank_o), 0);
        tick(0, 0, 0, 0);
        check("blink_1", int'(bus_if.disp_blank_o), 1);
        repeat (249) begin
            tick(0, 0, 0, 0);
            check_model("blink_b");
        end
        check("blink_1_held", int'(bus_if.disp_blank_o), 1);
        tick(0, 0, 0, 0);
        check("blink_2", int'(bus_if.disp_blank_o), 0);
        tick(0, 0, 0, 1);
        check("won_exit_state", int'(bus_if.state_o), 0);
        check("won_exit_blank", int'(bus_if.disp_blank_o), 0);

        // Deuce at 20:20
        repeat (20) begin
            tick(1, 0, 0, 0);
            tick(0, 1, 0, 0);
        end
        check("deuce_p1", int'(bus_if.score_p1_o), 20);
        check("deuce_p2", int'(bus_if.score_p2_o), 20);
        tick(1, 0, 0, 0);
        check("deuce_21_p1", int'(bus_if.score_p1_o), 21);
`ifdef SCOREBOARD_WIN_BY_TWO_EN
        check("deuce_21_state", int'(bus_if.state_o), 1);
        check("deuce_21_winner", int'(bus_if.winner_o), 0);
        tick(1, 0, 0, 0);
        check("deuce_22_p1", int'(bus_if.score_p1_o), 22);
        check("deuce_22_state", int'(bus_if.state_o), 2);
        check("deuce_22_winner", int'(bus_if.winner_o), 1);
`else
        check("deuce_21_state", int'(bus_if.state_o), 2);
        check("deuce_21_winner", int'(bus_if.winner_o), 1);
`endif
        check_model("deuce");
        tick(0, 0, 1, 0);

        // Randomized pulses against the model
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 999) == 0) begin
                async_reset("rnd_rst");
            end else begin
                tick($urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
                     $urandom_range(0, 299) == 0, $urandom_range(0, 299) == 0);
                check_model("rnd");
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
